// File: rtl/bus_pkg.sv
// Bus-wide defaults and the transfer state encoding shared by master and slave ports.
package bus_pkg;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } bus_state_t;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shifter, LSB first, zero-filled from the top.
// Load has priority over shift; output valid the cycle after load, no backpressure.
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= par_in;
        end else if (shift) begin
            sr <= sr >> 1;
        end
    end

    assign ser_out = sr[0];

endmodule

// File: rtl/master_out_port.sv
// Serial bus master: offers a transfer, waits for slave_ready, then shifts address/data LSB first.
// Latency: >=1 REQ cycle, ADDR_WIDTH SEND cycles, 1 DONE cycle; stalls in REQ until slave_ready or timeout.
module master_out_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  slave_ready,
    output logic                  master_valid,
    output logic                  tx_address,
    output logic                  tx_data,
    output logic                  busy,
    output logic                  tx_done,
    output logic                  tx_error
);

    localparam int CW = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(ADDR_WIDTH - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    bus_state_t    state;
    logic [CW-1:0] bit_cnt;
    logic [WW-1:0] wait_cnt;
    logic          wr_q;
    logic          load;
    logic          shift;
    logic          addr_ser;
    logic          data_ser;

    assign load  = (state == ST_IDLE) && start;
    assign shift = (state == ST_SEND);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            wr_q     <= 1'b0;
            tx_error <= 1'b0;
        end else begin
            tx_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_REQ;
                        wr_q     <= wr;
                        wait_cnt <= '0;
                    end
                end
                ST_REQ: begin
                    if (slave_ready) begin
                        state   <= ST_SEND;
                        bit_cnt <= '0;
                    end else if (TIMEOUT > 0 && wait_cnt == WAIT_LAST) begin
                        state    <= ST_IDLE;
                        tx_error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_SEND: begin
                    // slave_ready is deliberately ignored here: a started transfer always completes
                    if (bit_cnt == BIT_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    piso_shift #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .shift   (shift),
        .par_in  (addr_in),
        .ser_out (addr_ser)
    );

    // Zero fill means data bits beyond DATA_WIDTH come out as 0 without extra gating.
    piso_shift #(.WIDTH(DATA_WIDTH)) u_data_sr (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .shift   (shift),
        .par_in  (data_in),
        .ser_out (data_ser)
    );

    assign master_valid = (state == ST_REQ);
    assign busy         = (state != ST_IDLE);
    assign tx_done      = (state == ST_DONE);
    assign tx_address   = (state == ST_SEND) && addr_ser;
    assign tx_data      = (state == ST_SEND) && wr_q && data_ser;

endmodule

// File: tb/tb_master_out_port.sv
// Directed bench for master_out_port: table-driven transfers plus reset, held-start and timeout sequences.
module tb_master_out_port;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          wr;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          slave_ready;
    logic          master_valid;
    logic          tx_address;
    logic          tx_data;
    logic          busy;
    logic          tx_done;
    logic          tx_error;

    int checks = 0;
    int errors = 0;

    master_out_port #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .wr           (wr),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .slave_ready  (slave_ready),
        .master_valid (master_valid),
        .tx_address   (tx_address),
        .tx_data      (tx_data),
        .busy         (busy),
        .tx_done      (tx_done),
        .tx_error     (tx_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          wr;
        int            bp;
        logic [AW-1:0] exp_a;
        logic [AW-1:0] exp_d;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_valid"}, master_valid, 0);
        chk({name, "_addr"},  tx_address,   0);
        chk({name, "_data"},  tx_data,      0);
        chk({name, "_busy"},  busy,         0);
        chk({name, "_done"},  tx_done,      0);
        chk({name, "_err"},   tx_error,     0);
    endtask

    // Inputs change and outputs are sampled on the falling edge only.
    task automatic run_xfer(input vec_t v, input bit pulse_start);
        @(negedge clk);
        chk("pre_busy", busy, 0);
        start       = 1'b1;
        addr_in     = v.addr;
        data_in     = v.data;
        wr          = v.wr;
        slave_ready = (v.bp == 0);
        for (int j = 0; j <= v.bp; j++) begin
            @(negedge clk);
            chk("req_valid", master_valid, 1);
            chk("req_addr",  tx_address,   0);
            chk("req_err",   tx_error,     0);
            start       = 1'b0;
            addr_in     = ~v.addr;
            data_in     = ~v.data;
            slave_ready = (j == v.bp);
        end
        for (int i = 0; i < AW; i++) begin
            @(negedge clk);
            chk($sformatf("send_addr%0d", i), tx_address, v.exp_a[i]);
            chk($sformatf("send_data%0d", i), tx_data,    v.exp_d[i]);
            chk("send_valid", master_valid, 0);
            chk("send_done",  tx_done,      0);
            slave_ready = 1'b0;
            if (pulse_start) start = (i == 3);
        end
        @(negedge clk);
        start       = 1'b0;
        chk("done_pulse", tx_done, 1);
        chk("done_busy",  busy,    1);
        slave_ready = 1'b1;
        @(negedge clk);
        chk("post_done", tx_done, 0);
        chk("post_busy", busy,    0);
        chk("post_err",  tx_error, 0);
        if (pulse_start) begin
            @(negedge clk);
            chk("ignored_start_busy", busy, 0);
        end
    endtask

    initial begin
        int done_cnt;

        vecs[0] = '{addr: 12'hA5C, data: 8'h3B, wr: 1'b1, bp: 0, exp_a: 12'hA5C, exp_d: 12'h03B};
        vecs[1] = '{addr: 12'hFFF, data: 8'hAA, wr: 1'b0, bp: 0, exp_a: 12'hFFF, exp_d: 12'h000};
        vecs[2] = '{addr: 12'h555, data: 8'h01, wr: 1'b1, bp: 5, exp_a: 12'h555, exp_d: 12'h001};
        vecs[3] = '{addr: 12'h800, data: 8'h80, wr: 1'b1, bp: 0, exp_a: 12'h800, exp_d: 12'h080};
        vecs[4] = '{addr: 12'h001, data: 8'hFF, wr: 1'b1, bp: 0, exp_a: 12'h001, exp_d: 12'h0FF};

        reset       = 1'b1;
        start       = 1'b0;
        wr          = 1'b0;
        addr_in     = '0;
        data_in     = '0;
        slave_ready = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 4; k++) run_xfer(vecs[k], k == 3);

        // Reset asserted while SEND is driving address bit 5.
        @(negedge clk);
        start       = 1'b1;
        addr_in     = 12'hFFF;
        data_in     = 8'hFF;
        wr          = 1'b1;
        slave_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 5; i++) @(negedge clk);
        chk("rst_bit5_addr", tx_address, 1);
        #1 reset = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after_rst_done", tx_done, 0);
            chk("after_rst_busy", busy,    0);
        end
        run_xfer(vecs[4], 1'b0);

        // start held through a whole transfer: the next one begins only after DONE.
        @(negedge clk);
        start       = 1'b1;
        addr_in     = 12'h0C3;
        data_in     = 8'h5A;
        wr          = 1'b1;
        slave_ready = 1'b1;
        @(negedge clk);
        chk("held_req", master_valid, 1);
        for (int i = 0; i < AW; i++) @(negedge clk);
        chk("held_last_addr", tx_address, 0);
        @(negedge clk);
        chk("held_done", tx_done, 1);
        @(negedge clk);
        chk("held_idle_busy", busy, 0);
        @(negedge clk);
        chk("held_req2_valid", master_valid, 1);
        chk("held_req2_busy",  busy,         1);
        start    = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < AW + 2; i++) begin
            @(negedge clk);
            if (tx_done) done_cnt++;
        end
        chk("held_done_count", done_cnt, 1);
        chk("held_end_busy", busy, 0);

        // Timeout: slave never ready.
        @(negedge clk);
        start       = 1'b1;
        slave_ready = 1'b0;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("to_valid%0d", i), master_valid, 1);
            chk("to_err_early", tx_error, 0);
        end
        @(negedge clk);
        chk("to_err",   tx_error,     1);
        chk("to_busy",  busy,         0);
        chk("to_valid", master_valid, 0);
        chk("to_done",  tx_done,      0);
        @(negedge clk);
        chk("to_err_clear", tx_error, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
